mac_seq_ctrl: RTL and testbench



---
 rtl/mac_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for the MAC array datapath.
// A job is started by a one-cycle start pulse. The sequencer then:
//   1. preloads K*K weight words from BRAM,
//   2. commits the weights to the MAC array,
//   3. streams the ifmap vectors,
//   4. drains the psum pipeline.
// Optional feature macro: MAC_SEQ_PERF_EN. When it is defined, a saturating
// STREAM stall counter is built and reported in axi_control_3[31:16].
module mac_seq_ctrl #(
  parameter int MAC_NUM            = 256,
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int KMAX               = 5,
  parameter int CNT_W              = 16,
  parameter int PSUM_LAT           = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [4:0]                    kernel_size,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] weight_base_addr,
  input  logic [CNT_W-1:0]              ifmap_count,
  input  logic [MAC_NUM-1:0]            enable_mask,
  input  logic                          ifmaps_fifo_empty,
  input  logic                          psum_ready,
  output logic                          ifmaps_fifo_rd,
  output logic                          bram_rd_en,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
  output logic                          load_weight_preload,
  output logic                          load_MAC_weight,
  output logic                          load_ifmaps,
  output logic                          psum_valid,
  output logic [MAC_NUM-1:0]            mac_enable,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   axi_control_3
);

  // Preload counter must reach K*K (one past the last read) for KMAX.
  localparam int PW = $clog2(KMAX * KMAX + 2);
  localparam int DW = (PSUM_LAT > 1) ? $clog2(PSUM_LAT) : 1;
  localparam logic [4:0] KMAX_K = 5'(KMAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRELOAD = 3'd1,
    LOAD_W  = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                        state_reg;
  logic [PW-1:0]                 kk_reg;
  logic [PW-1:0]                 pre_cnt_reg;
  logic [CNT_W-1:0]              rem_reg;
  logic [DW-1:0]                 drain_cnt_reg;
  logic                          done_sticky_reg;
  logic                          err_sticky_reg;
  logic                          bram_rd_en_reg;
  logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_reg;
  logic                          load_weight_preload_reg;
  logic                          load_mac_weight_reg;
  logic                          done_reg;
  logic [MAC_NUM-1:0]            mac_enable_reg;
  logic [PSUM_LAT-1:0]           psum_sr_reg;
  logic [15:0]                   perf_word;

  logic          k_legal;
  logic [PW-1:0] ks_w;
  logic [PW-1:0] kk_next;
  logic          pop;

  assign k_legal = (kernel_size != 5'd0) && (kernel_size <= KMAX_K);
  assign ks_w    = PW'(kernel_size);
  assign kk_next = ks_w * ks_w;
  // A pop happens in STREAM whenever data is present and downstream can take a psum.
  assign pop     = (state_reg == STREAM) && !ifmaps_fifo_empty && psum_ready;

  // Main sequencing FSM with registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg               <= IDLE;
      kk_reg                  <= '0;
      pre_cnt_reg             <= '0;
      rem_reg                 <= '0;
      drain_cnt_reg           <= '0;
      done_sticky_reg         <= 1'b0;
      err_sticky_reg          <= 1'b0;
      bram_rd_en_reg          <= 1'b0;
      bram_addr_reg           <= '0;
      load_weight_preload_reg <= 1'b0;
      load_mac_weight_reg     <= 1'b0;
      done_reg                <= 1'b0;
      mac_enable_reg          <= '0;
    end else begin
      // BRAM data arrives one cycle after the read strobe.
      load_weight_preload_reg <= bram_rd_en_reg;
      load_mac_weight_reg     <= 1'b0;
      done_reg                <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (k_legal) begin
              kk_reg          <= kk_next;
              pre_cnt_reg     <= '0;
              rem_reg         <= ifmap_count;
              bram_rd_en_reg  <= 1'b1;
              bram_addr_reg   <= weight_base_addr;
              mac_enable_reg  <= enable_mask;
              done_sticky_reg <= 1'b0;
              err_sticky_reg  <= 1'b0;
              state_reg       <= PRELOAD;
            end else begin
              err_sticky_reg <= 1'b1;
            end
          end
        end
        PRELOAD: begin
          pre_cnt_reg <= pre_cnt_reg + 1'b1;
          if ((pre_cnt_reg + 1'b1) < kk_reg) begin
            bram_addr_reg <= bram_addr_reg + 1'b1;
          end else begin
            bram_rd_en_reg <= 1'b0;
          end
          // The extra cycle after the last read lets the final word land.
          if (pre_cnt_reg == kk_reg) begin
            load_mac_weight_reg <= 1'b1;
            state_reg           <= LOAD_W;
          end
        end
        LOAD_W: begin
          drain_cnt_reg <= '0;
          state_reg     <= (rem_reg == '0) ? DRAIN : STREAM;
        end
        STREAM: begin
          drain_cnt_reg <= '0;
          if (pop) begin
            rem_reg <= rem_reg - 1'b1;
            if (rem_reg == CNT_W'(1)) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == DW'(PSUM_LAT - 1)) begin
            done_reg        <= 1'b1;
            done_sticky_reg <= 1'b1;
            state_reg       <= DONE;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          mac_enable_reg <= '0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Psum valid tracks each pop through the MAC pipeline latency.
  generate
    if (PSUM_LAT == 1) begin : g_psum1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) psum_sr_reg <= '0;
        else        psum_sr_reg <= pop;
      end
    end else begin : g_psumn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) psum_sr_reg <= '0;
        else        psum_sr_reg <= {psum_sr_reg[PSUM_LAT-2:0], pop};
      end
    end
  endgenerate

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] stall_cnt_reg;
  // Saturating count of STREAM cycles that did not pop; restarts with each accepted job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == IDLE && start && k_legal) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == STREAM && !pop && stall_cnt_reg != 16'hFFFF) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end
  assign perf_word = stall_cnt_reg;
`else
  assign perf_word = 16'd0;
`endif

  assign ifmaps_fifo_rd      = pop;
  assign load_ifmaps         = pop;
  assign bram_rd_en          = bram_rd_en_reg;
  assign bram_addr           = bram_addr_reg;
  assign load_weight_preload = load_weight_preload_reg;
  assign load_MAC_weight     = load_mac_weight_reg;
  assign psum_valid          = psum_sr_reg[PSUM_LAT-1];
  assign mac_enable          = mac_enable_reg;
  assign busy                = (state_reg != IDLE);
  assign done                = done_reg;
  assign axi_control_3       = {perf_word, 10'd0, state_reg, err_sticky_reg, done_sticky_reg, busy};

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed and randomized jobs checked against a cycle-timeline model.
module tb_mac_seq_ctrl;

  localparam int MN = 256;
  localparam int AW = 12;
  localparam int CW = 16;
  localparam int PL = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [4:0]    kernel_size;
  logic [AW-1:0] weight_base_addr;
  logic [CW-1:0] ifmap_count;
  logic [MN-1:0] enable_mask;
  logic          ifmaps_fifo_empty;
  logic          psum_ready;
  logic          ifmaps_fifo_rd;
  logic          bram_rd_en;
  logic [AW-1:0] bram_addr;
  logic          load_weight_preload;
  logic          load_MAC_weight;
  logic          load_ifmaps;
  logic          psum_valid;
  logic [MN-1:0] mac_enable;
  logic          busy;
  logic          done;
  logic [31:0]   axi_control_3;

  int checks = 0;
  int errors = 0;
  bit pop_hist [0:4095];

  mac_seq_ctrl #(
    .MAC_NUM(MN), .BRAM_ADDRESS_WIDTH(AW), .KMAX(5), .CNT_W(CW), .PSUM_LAT(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_size(kernel_size),
    .weight_base_addr(weight_base_addr), .ifmap_count(ifmap_count),
    .enable_mask(enable_mask), .ifmaps_fifo_empty(ifmaps_fifo_empty),
    .psum_ready(psum_ready), .ifmaps_fifo_rd(ifmaps_fifo_rd),
    .bram_rd_en(bram_rd_en), .bram_addr(bram_addr),
    .load_weight_preload(load_weight_preload), .load_MAC_weight(load_MAC_weight),
    .load_ifmaps(load_ifmaps), .psum_valid(psum_valid), .mac_enable(mac_enable),
    .busy(busy), .done(done), .axi_control_3(axi_control_3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " fifo_rd"}, ifmaps_fifo_rd, 0);
    chk({tag, " bram_rd_en"}, bram_rd_en, 0);
    chk({tag, " bram_addr"}, bram_addr, 0);
    chk({tag, " preload"}, load_weight_preload, 0);
    chk({tag, " load_w"}, load_MAC_weight, 0);
    chk({tag, " load_ifmaps"}, load_ifmaps, 0);
    chk({tag, " psum_valid"}, psum_valid, 0);
    chk({tag, " mac_enable"}, mac_enable, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " status"}, axi_control_3, 0);
  endtask

  // Runs one job from cycle 0 (start sampled) and checks every cycle against the
  // job timeline: PRELOAD 1..KK+1, LOAD_W KK+2, STREAM until N pops, DRAIN PL cycles, DONE.
  task automatic run_job(input int k, input int base, input int n, input int mode,
                         input int abort_at, input int extra_at);
    int kk, t, pops, drain_start, stall, ph, perf_exp;
    logic exp_pop;
    logic [MN-1:0] mask;
    string tg;
    kk = k * k;
    for (int i = 0; i < 4096; i++) pop_hist[i] = 1'b0;
    for (int i = 0; i < MN / 32; i++) mask[i*32 +: 32] = $urandom;
    start = 1'b1;
    kernel_size = 5'(k);
    weight_base_addr = AW'(base);
    ifmap_count = CW'(n);
    enable_mask = mask;
    @(posedge clk); #1;
    t = 1; pops = 0; drain_start = -1; stall = 0;
    while (1) begin
      kernel_size = 5'($urandom);
      weight_base_addr = AW'($urandom);
      ifmap_count = CW'($urandom);
      enable_mask = ~mask;
      if (t == extra_at) begin
        start = 1'b1;
        kernel_size = 5'd5;
      end else begin
        start = 1'b0;
      end
      case (mode)
        0: begin ifmaps_fifo_empty = 1'b0; psum_ready = 1'b1; end
        1: begin ifmaps_fifo_empty = (t == 13 || t == 14); psum_ready = (t != 16); end
        default: begin
          ifmaps_fifo_empty = ($urandom_range(0, 3) == 0);
          psum_ready = ($urandom_range(0, 3) != 0);
        end
      endcase
      if (t == abort_at) begin
        start = 1'b0;
        ifmaps_fifo_empty = 1'b0;
        psum_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) begin
          @(negedge clk);
          check_all_zero("abort_hold");
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("job k=%0d base=%0h n=%0d aborted at cycle %0d", k, base, n, t);
        return;
      end
      if (t <= kk + 1) ph = 1;
      else if (t == kk + 2) ph = 2;
      else if (pops < n) ph = 3;
      else begin
        if (drain_start < 0) drain_start = t;
        if (t < drain_start + PL) ph = 4;
        else if (t == drain_start + PL) ph = 5;
        else ph = 0;
      end
      exp_pop = (ph == 3) && !ifmaps_fifo_empty && psum_ready;
      @(negedge clk);
      tg = $sformatf("k%0d c%0d", k, t);
      chk({tg, " fifo_rd"}, ifmaps_fifo_rd, exp_pop);
      chk({tg, " load_ifmaps"}, load_ifmaps, exp_pop);
      chk({tg, " bram_rd_en"}, bram_rd_en, (ph == 1) && (t <= kk));
      if ((ph == 1) && (t <= kk)) chk({tg, " bram_addr"}, bram_addr, (base + t - 1) % 4096);
      chk({tg, " preload"}, load_weight_preload, (ph == 1) && (t >= 2));
      chk({tg, " load_w"}, load_MAC_weight, ph == 2);
      chk({tg, " psum_valid"}, psum_valid, (t >= PL) ? pop_hist[t - PL] : 1'b0);
      chk({tg, " mac_enable"}, mac_enable, (ph != 0) ? mask : '0);
      chk({tg, " busy"}, busy, ph != 0);
      chk({tg, " done"}, done, ph == 5);
      chk({tg, " status"}, {axi_control_3[15:2], axi_control_3[0]},
          {10'd0, 3'(ph), 1'b0, ph != 0});
      if (ph >= 1 && ph <= 4) chk({tg, " done_sticky"}, axi_control_3[1], 0);
      if (exp_pop) begin
        pops++;
        pop_hist[t] = 1'b1;
      end
      if (ph == 3 && !exp_pop) stall++;
      if (ph == 0) break;
      if (t > 3000) begin
        chk({tg, " timeout"}, 1, 0);
        break;
      end
      @(posedge clk); #1;
      t++;
    end
`ifdef MAC_SEQ_PERF_EN
    perf_exp = (stall > 65535) ? 65535 : stall;
`else
    perf_exp = 0;
`endif
    chk("post done_sticky", axi_control_3[1], 1);
    chk("post perf", axi_control_3[31:16], perf_exp);
    $display("job k=%0d base=%0h n=%0d mode=%0d finished, done at cycle %0d, stalls %0d",
             k, base, n, mode, drain_start + PL, stall);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reject(input logic [4:0] ks);
    start = 1'b1;
    kernel_size = ks;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk($sformatf("reject k%0d busy", ks), busy, 0);
    chk($sformatf("reject k%0d err", ks), axi_control_3[2], 1);
    chk($sformatf("reject k%0d state", ks), axi_control_3[5:3], 0);
    $display("start with kernel_size=%0d rejected check done", ks);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    kernel_size = '0;
    weight_base_addr = '0;
    ifmap_count = '0;
    enable_mask = '0;
    ifmaps_fifo_empty = 1'b1;
    psum_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(3, 'h100, 4, 0, 0, 0);
    run_job(3, 'h100, 4, 1, 0, 0);
    reject(5'd0);
    reject(5'd6);
    run_job(3, 'h100, 4, 0, 0, 0);
    run_job(1, 'hFFF, 0, 0, 0, 0);
    run_job(2, 'hFFF, 2, 0, 0, 0);
    run_job(3, 'h100, 4, 0, 13, 0);
    run_job(3, 'h100, 4, 0, 0, 0);
    run_job(3, 'h100, 4, 0, 0, 5);
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(1, 5)), int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 8)), 2, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
